msg_write: RTL
==============

Name: msg_write

Overview:
- Response framer downstream of msg_read on the OPB side.
- Captures OPB read data after each OPB_RE strobe and serialises a 10-byte read-response frame into the TX FIFO.
- Turns error_flag pulses into a 3-byte error frame.
- Frames are byte-symmetric with the RX command format so the host parser is shared.

Parameters:
- RD_LAT, 2: OPB_CLK cycles from the OPB_RE strobe to valid OPB_DI; legal range 1..15.
- TX_TIMEOUT, 200: PULSE_2KHZ rising edges with TX_FIFO_FULL held high before the frame is aborted.
- HDR_RD, 8'h5B: read-response header.
- HDR_ERR, 8'h5E: error-frame header.
- TAIL, 8'hA4: frame tail.

Ports:
- OPB_CLK  in  1  system clock.
- OPB_RST  in  1  synchronous, active-high reset.
- PULSE_2KHZ  in  1  timebase; rising edge detected internally.
- OPB_RE  in  1  read strobe from msg_read, one cycle.
- OPB_ADDR  in  32  read address, valid with OPB_RE.
- OPB_DI  in  32  OPB read data, valid RD_LAT cycles after OPB_RE.
- ERR_IN  in  1  error_flag from msg_read, level or pulse; rising edge used.
- TX_FIFO_WR  out  1  TX FIFO write enable.
- TX_FIFO_DATA  out  8  TX FIFO write data.
- TX_FIFO_FULL  in  1  TX FIFO full.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- OVERRUN  out  1  one-cycle pulse when a request is dropped.
- TX_TIMEOUT_FLAG  out  1  one-cycle pulse on frame abort.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; err_cnt 0; err_pend 0; byte index 0; timeout counter 0.
- FSM states: IDLE, WAIT_DATA, SEND_RD, SEND_ERR.
- IDLE:
  - OPB_RE=1 -> latch OPB_ADDR, load lat_cnt=RD_LAT-1, go to WAIT_DATA.
  - Else err_pend=1 -> clear err_pend, go to SEND_ERR.
- WAIT_DATA:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, latch OPB_DI and go to SEND_RD.
  - Total capture delay is exactly RD_LAT cycles after OPB_RE.
- SEND_RD, byte order idx 0..9: HDR_RD, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], DATA[31:24], DATA[23:16], DATA[15:8], DATA[7:0], TAIL.
- SEND_ERR, byte order idx 0..2: HDR_ERR, err_cnt, TAIL.
  - err_cnt is an 8-bit count of ERR_IN rising edges; it wraps 255 -> 0.
  - The value sent is the count at the moment the frame starts.
- Write handshake:
  - In a SEND state with TX_FIFO_FULL=0: TX_FIFO_WR=1 with the current byte, then idx increments.
  - With TX_FIFO_FULL=1: TX_FIFO_WR=0, idx holds.
  - Registered outputs: byte k appears one cycle after the FSM decides to send it.
  - Full-throughput frame: 10 consecutive TX_FIFO_WR cycles.
  - After the tail write, return to IDLE; the next frame may start on the following cycle.
- ERR_IN rising edge:
  - Always increments err_cnt and sets err_pend.
  - Any state accepts it; it never preempts a frame.
  - A second edge while err_pend=1 still counts but yields only one error frame.
- Simultaneous OPB_RE and pending error in IDLE: the read wins; the error frame follows.
- OPB_RE while not IDLE: request dropped, OVERRUN pulses, state unaffected.
- Timeout:
  - In a SEND state, count PULSE_2KHZ rising edges while TX_FIFO_FULL=1.
  - The counter clears on any successful write.
  - Reaching TX_TIMEOUT -> abort, TX_TIMEOUT_FLAG pulses, go to IDLE. The partial frame is left in the FIFO and the host resyncs on the header.
- OPB_RST mid-frame: immediate return to reset values on the next edge; no further writes; pending error lost.

Decomposition:
- Package msg_pkg:
  - Header/tail constants HDR_WR=8'h5A, HDR_RD, HDR_ERR, TAIL_WR=8'hA5, TAIL.
  - Frame lengths 10 and 3.
  - FSM state enum.
  - msg_read is to import the same package.
- Sub-module pulse_timer: PULSE_2KHZ edge detect plus saturating timeout counter (clear, enable, limit, expired). It is reusable by msg_read's timeout.

Test Plan:
- Read frame, RD_LAT=2, FIFO never full:
  - Stimulus: OPB_RE with ADDR=32'h12345678, OPB_DI=32'hCAFEF00D two cycles later.
  - Response: FIFO receives 5B 12 34 56 78 CA FE F0 0D A4 on 10 consecutive writes.
- Backpressure:
  - Stimulus: same read, TX_FIFO_FULL forced high for 4 cycles after byte 3.
  - Response: no writes while full; byte order is intact; total of 10 writes.
- Error frames:
  - Stimulus: three ERR_IN edges while IDLE, spaced at least 20 cycles apart.
  - Response: frames 5E 01 A4, then 5E 02 A4, then 5E 03 A4.
- Overrun and priority:
  - Stimulus: second OPB_RE during SEND_RD.
  - Response: OVERRUN pulses once, only one read frame is written.
  - Stimulus: OPB_RE in the same cycle as an ERR_IN edge.
  - Response: read frame first, then 5E xx A4.
- Timeout:
  - Stimulus: TX_FIFO_FULL held high after byte 2 for more than 200 PULSE_2KHZ edges.
  - Response: TX_TIMEOUT_FLAG pulses once, BUSY=0, and the next OPB_RE produces a full correct frame.
- Reset mid-frame:
  - Stimulus: OPB_RST for 1 cycle at byte 5.
  - Response: TX_FIFO_WR=0 from the next cycle, all outputs 0, and a subsequent read frame is correct.

Source files
------------

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared frame constants, FSM state type and frame byte helpers for msg_read/msg_write
package msg_pkg;

  localparam logic [7:0] HDR_WR  = 8'h5A;
  localparam logic [7:0] HDR_RD  = 8'h5B;
  localparam logic [7:0] HDR_ERR = 8'h5E;
  localparam logic [7:0] TAIL_WR = 8'hA5;
  localparam logic [7:0] TAIL    = 8'hA4;

  localparam logic [3:0] RD_FRAME_LEN  = 4'd10;
  localparam logic [3:0] ERR_FRAME_LEN = 4'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SEND_RD   = 2'd2,
    SEND_ERR  = 2'd3
  } state_e;

  // Big-endian address then data, bracketed by header and tail.
  function automatic logic [7:0] rd_frame_byte(input logic [3:0]  idx,
                                               input logic [31:0] addr,
                                               input logic [31:0] data);
    case (idx)
      4'd0:    return HDR_RD;
      4'd1:    return addr[31:24];
      4'd2:    return addr[23:16];
      4'd3:    return addr[15:8];
      4'd4:    return addr[7:0];
      4'd5:    return data[31:24];
      4'd6:    return data[23:16];
      4'd7:    return data[15:8];
      4'd8:    return data[7:0];
      default: return TAIL;
    endcase
  endfunction

  function automatic logic [7:0] err_frame_byte(input logic [3:0] idx,
                                                input logic [7:0] cnt);
    case (idx)
      4'd0:    return HDR_ERR;
      4'd1:    return cnt;
      default: return TAIL;
    endcase
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - timebase rising-edge detector with a saturating, clearable timeout counter
module pulse_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pulse_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic         pulse_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         rise;

  assign rise      = pulse_i & ~pulse_q;
  assign expired_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && rise && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= pulse_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_write.sv
// rtl/msg_write.sv - OPB read-response and error-frame serialiser into the TX FIFO
module msg_write #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned TX_TIMEOUT = 200
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_2KHZ,
  input  logic        OPB_RE,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  input  logic        ERR_IN,
  output logic        TX_FIFO_WR,
  output logic [7:0]  TX_FIFO_DATA,
  input  logic        TX_FIFO_FULL,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic        TX_TIMEOUT_FLAG
);

  import msg_pkg::*;

  localparam logic [3:0]  LAT_LOAD = 4'(RD_LAT - 1);
  localparam logic [15:0] TO_LIMIT = 16'(TX_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  err_snap_q, err_snap_d;
  logic        err_pend_q, err_pend_d;
  logic        err_in_q;
  logic        wr_q, wr_d;
  logic [7:0]  byte_q, byte_d;
  logic        ovr_q, ovr_d;
  logic        to_q, to_d;

  logic        err_rise;
  logic [7:0]  cur_byte;
  logic [3:0]  last_idx;
  logic        tmr_clear, tmr_en, tmr_expired;

  assign err_rise = ERR_IN & ~err_in_q;

  always_comb begin
    cur_byte = rd_frame_byte(idx_q, addr_q, data_q);
    last_idx = RD_FRAME_LEN - 4'd1;
    if (state_q == SEND_ERR) begin
      cur_byte = err_frame_byte(idx_q, err_snap_q);
      last_idx = ERR_FRAME_LEN - 4'd1;
    end
  end

  pulse_timer #(.W(16)) u_timer (
    .clk_i     (OPB_CLK),
    .rst_i     (OPB_RST),
    .pulse_i   (PULSE_2KHZ),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .limit_i   (TO_LIMIT),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_cnt_d  = err_cnt_q;
    err_snap_d = err_snap_q;
    err_pend_d = err_pend_q;
    wr_d       = 1'b0;
    byte_d     = byte_q;
    ovr_d      = OPB_RE && (state_q != IDLE);
    to_d       = 1'b0;
    tmr_clear  = 1'b1;
    tmr_en     = 1'b0;

    if (err_rise) begin
      err_cnt_d  = err_cnt_q + 8'd1;
      err_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        if (OPB_RE) begin
          addr_d  = OPB_ADDR;
          lat_d   = LAT_LOAD;
          state_d = WAIT_DATA;
        end else if (err_pend_q) begin
          // An edge arriving this very cycle is not in the snapshot, so keep it pending.
          err_pend_d = err_rise;
          err_snap_d = err_cnt_q;
          state_d    = SEND_ERR;
        end
      end
      WAIT_DATA: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd0) begin
          data_d  = OPB_DI;
          state_d = SEND_RD;
        end
      end
      SEND_RD, SEND_ERR: begin
        tmr_clear = 1'b0;
        tmr_en    = TX_FIFO_FULL;
        if (tmr_expired) begin
          to_d    = 1'b1;
          idx_d   = 4'd0;
          state_d = IDLE;
        end else if (!TX_FIFO_FULL) begin
          wr_d      = 1'b1;
          byte_d    = cur_byte;
          tmr_clear = 1'b1;
          if (idx_q == last_idx) begin
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      lat_q      <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      err_cnt_q  <= 8'd0;
      err_snap_q <= 8'd0;
      err_pend_q <= 1'b0;
      err_in_q   <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 8'd0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_cnt_q  <= err_cnt_d;
      err_snap_q <= err_snap_d;
      err_pend_q <= err_pend_d;
      err_in_q   <= ERR_IN;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
    end
  end

  assign TX_FIFO_WR      = wr_q;
  assign TX_FIFO_DATA    = byte_q;
  assign BUSY            = (state_q != IDLE);
  assign OVERRUN         = ovr_q;
  assign TX_TIMEOUT_FLAG = to_q;

endmodule
